// File: rtl/music_pkg.sv
// Shared definitions for the score sequencer and the buzzer tone generator:
// FSM states, tempo codes, note/octave widths and the tone request struct.
package music_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] TEMPO_NORMAL = 2'b00;
  localparam logic [1:0] TEMPO_FAST   = 2'b01;
  localparam logic [1:0] TEMPO_SLOW   = 2'b10;

  localparam int NOTE_W = 3;
  localparam int OCT_W  = 2;

  localparam logic [NOTE_W-1:0] NOTE_REST = '0;
  localparam logic [OCT_W-1:0]  OCT_LOW   = 2'd0;
  localparam logic [OCT_W-1:0]  OCT_MID   = 2'd1;
  localparam logic [OCT_W-1:0]  OCT_HIGH  = 2'd2;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [OCT_W-1:0]  octave;
    logic              valid;
  } tone_t;

  // Only nibble values 1..7 name a note (do..ti); 0 and 8..15 are rests.
  function automatic logic nibble_is_note(input logic [3:0] nib);
    return (nib != 4'd0) && (nib <= 4'd7);
  endfunction

endpackage

// File: rtl/music_note_decode.sv
// Combinational score-word decoder: {high,med,low} nibbles -> note/octave/valid.
// The highest non-zero nibble selects the octave; an out-of-range pick is a rest.
module music_note_decode
  import music_pkg::*;
#(
  parameter int ROM_WIDTH = 12
) (
  input  logic [ROM_WIDTH-1:0] rom_word,
  output tone_t                tone
);

  logic [3:0]       sel;
  logic [OCT_W-1:0] oct;

  always_comb begin
    sel = rom_word[3:0];
    oct = OCT_LOW;
    if (rom_word[11:8] != 4'd0) begin
      sel = rom_word[11:8];
      oct = OCT_HIGH;
    end else if (rom_word[7:4] != 4'd0) begin
      sel = rom_word[7:4];
      oct = OCT_MID;
    end

    tone = '{note: NOTE_REST, octave: OCT_LOW, valid: 1'b0};
    if (nibble_is_note(sel)) begin
      tone = '{note: sel[2:0], octave: oct, valid: 1'b1};
    end
  end

endmodule

// File: rtl/music_player_ctrl.sv
// Score sequencer: steps the ROM address once per beat and drives a registered
// tone request; play/pause/stop commands, loop mode and three tempos.
module music_player_ctrl
  import music_pkg::*;
#(
  parameter int ROM_WIDTH   = 12,
  parameter int ROM_DEPTH   = 128,
  parameter int ADDR_WIDTH  = 7,
  parameter int BEAT_CYCLES = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  play,
  input  logic                  pause,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [1:0]            tempo_sel,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]  rom_data,
  output logic [NOTE_W-1:0]     note,
  output logic [OCT_W-1:0]      octave,
  output logic                  note_valid,
  output logic                  busy,
  output logic                  song_end
);

  localparam int CNT_W = $clog2(2 * BEAT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROM_DEPTH - 1);

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_last;
  logic             beat_end;
  logic             last_beat;
  logic             song_stops;
  tone_t            dec;

  music_note_decode #(.ROM_WIDTH(ROM_WIDTH)) u_decode (
    .rom_word (rom_data),
    .tone     (dec)
  );

  always_comb begin
    case (tempo_sel)
      TEMPO_FAST:   beat_last = CNT_W'(BEAT_CYCLES / 2 - 1);
      TEMPO_SLOW:   beat_last = CNT_W'(BEAT_CYCLES * 2 - 1);
      TEMPO_NORMAL: beat_last = CNT_W'(BEAT_CYCLES - 1);
      default:      beat_last = CNT_W'(BEAT_CYCLES - 1);
    endcase
  end

  // ">=" so a tempo change to a shorter beat ends an overrun beat at once.
  assign beat_end   = (beat_cnt >= beat_last);
  assign last_beat  = beat_end && (rom_addr == LAST_ADDR);
  assign song_stops = last_beat && !loop_en;
  assign busy       = (state == ST_PLAY) || (state == ST_PAUSE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rom_addr   <= '0;
      beat_cnt   <= '0;
      note       <= NOTE_REST;
      octave     <= OCT_LOW;
      note_valid <= 1'b0;
      song_end   <= 1'b0;
    end else begin
      song_end   <= 1'b0;
      note       <= NOTE_REST;
      octave     <= OCT_LOW;
      note_valid <= 1'b0;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (stop) begin
            state    <= ST_IDLE;
            rom_addr <= '0;
            beat_cnt <= '0;
          end else if (play) begin
            state    <= ST_PLAY;
            rom_addr <= '0;
            beat_cnt <= '0;
          end
        end

        ST_PAUSE: begin
          if (stop) begin
            state    <= ST_IDLE;
            rom_addr <= '0;
            beat_cnt <= '0;
          end else if (play) begin
            state <= ST_PLAY;
          end
        end

        ST_PLAY: begin
          if (stop) begin
            state    <= ST_IDLE;
            rom_addr <= '0;
            beat_cnt <= '0;
          end else if (pause && !play) begin
            state <= ST_PAUSE;
          end else begin
            // Tone tracks the address with one cycle of latency; suppressed when
            // this cycle hands over to DONE so DONE shows a rest.
            if (!song_stops) begin
              note       <= dec.note;
              octave     <= dec.octave;
              note_valid <= dec.valid;
            end
            if (beat_end) begin
              beat_cnt <= '0;
              if (last_beat) begin
                rom_addr <= '0;
                song_end <= 1'b1;
                if (!loop_en) state <= ST_DONE;
              end else begin
                rom_addr <= rom_addr + ADDR_WIDTH'(1);
              end
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_music_player_ctrl.sv
// Bench for music_player_ctrl with an 8-entry stub score and 4-cycle beats,
// compared cycle by cycle against a beat/position reference model.
module tb_music_player_ctrl;

  localparam int BC    = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst, play, pause, stop, loop_en;
  logic [1:0]    tempo_sel;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_data;
  logic [2:0]    note;
  logic [1:0]    octave;
  logic          note_valid, busy, song_end;

  int rom [DEPTH] = '{'h001, 'h001, 'h005, 'h000, 'h010, 'h300, 'h0F0, 'h004};

  assign rom_data = 12'(rom[rom_addr]);

  always #5 clk = ~clk;

  music_player_ctrl #(
    .ROM_WIDTH(12), .ROM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .BEAT_CYCLES(BC)
  ) dut (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
    .loop_en(loop_en), .tempo_sel(tempo_sel), .rom_addr(rom_addr),
    .rom_data(rom_data), .note(note), .octave(octave),
    .note_valid(note_valid), .busy(busy), .song_end(song_end)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: what the player is doing, where it is in the score, and
  // how many cycles of the current beat have elapsed.
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_DONE = 3;
  int m_mode = M_IDLE, m_pos = 0, m_elapsed = 0;
  int e_note = 0, e_oct = 0, e_vld = 0, e_end = 0;

  function automatic void tone_of(input int w, output int n, output int o, output int v);
    int h, m, l, pick;
    h = w / 256; m = (w / 16) % 16; l = w % 16;
    if (h != 0)      begin pick = h; o = 2; end
    else if (m != 0) begin pick = m; o = 1; end
    else             begin pick = l; o = 0; end
    v = (pick >= 1 && pick <= 7) ? 1 : 0;
    n = v ? pick : 0;
    if (!v) o = 0;
  endfunction

  task automatic model_step(input logic p, input logic pa, input logic st, input logic r);
    int beat_len, n, o, v;
    bit over;
    e_note = 0; e_oct = 0; e_vld = 0; e_end = 0;
    if (r) begin
      m_mode = M_IDLE; m_pos = 0; m_elapsed = 0;
    end else if (st) begin
      m_mode = M_IDLE; m_pos = 0; m_elapsed = 0;
    end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
      if (p) begin m_mode = M_PLAY; m_pos = 0; m_elapsed = 0; end
    end else if (m_mode == M_PAUSE) begin
      if (p) m_mode = M_PLAY;
    end else if (pa && !p) begin
      m_mode = M_PAUSE;
    end else begin
      beat_len = (tempo_sel == 2'd1) ? BC / 2 : (tempo_sel == 2'd2) ? BC * 2 : BC;
      over = (m_elapsed + 1 >= beat_len);
      if (!(over && m_pos == DEPTH - 1 && !loop_en)) begin
        tone_of(rom[m_pos], n, o, v);
        e_note = n; e_oct = o; e_vld = v;
      end
      if (over) begin
        m_elapsed = 0;
        if (m_pos == DEPTH - 1) begin
          e_end = 1; m_pos = 0;
          if (!loop_en) m_mode = M_DONE;
        end else begin
          m_pos = m_pos + 1;
        end
      end else begin
        m_elapsed = m_elapsed + 1;
      end
    end
  endtask

  function automatic logic [10:0] obs();
    return {rom_addr, note, octave, note_valid, busy, song_end};
  endfunction

  function automatic logic [10:0] expv();
    logic b;
    b = (m_mode == M_PLAY || m_mode == M_PAUSE);
    return {AW'(m_pos), 3'(e_note), 2'(e_oct), 1'(e_vld), b, 1'(e_end)};
  endfunction

  function automatic string fmt(input logic [10:0] x);
    return $sformatf("addr=%0d note=%0d oct=%0d vld=%0b busy=%0b end=%0b",
                     x[10:8], x[7:5], x[4:3], x[2], x[1], x[0]);
  endfunction

  task automatic step(input logic p, input logic pa, input logic st, input logic r);
    play = p; pause = pa; stop = st; rst = r;
    @(posedge clk);
    model_step(p, pa, st, r);
    #1;
    play = 1'b0; pause = 1'b0; stop = 1'b0; rst = 1'b0;
    cyc++;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs() !== 11'd0) begin
      n_fail++; $display("FAIL reset_state: got %s, want all zero", fmt(obs()));
    end
  endtask

  task automatic test_play_sequence();
    int ends = 0;
    loop_en = 1'b0; tempo_sel = 2'd0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (busy !== 1'b1 || note_valid !== 1'b0) begin
      n_fail++; $display("FAIL play_start: busy=%0b vld=%0b, want busy=1 vld=0", busy, note_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({note, octave, note_valid} !== {3'd1, 2'd0, 1'b1}) begin
      n_fail++; $display("FAIL first_note: %s, want note=1 oct=0 vld=1", fmt(obs()));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rom_addr !== 3'd0) begin
      n_fail++; $display("FAIL beat_hold: addr=%0d, want 0", rom_addr);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rom_addr !== 3'd1) begin
      n_fail++; $display("FAIL beat_step: addr=%0d, want 1", rom_addr);
    end
    for (int k = 0; k < 36; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (song_end === 1'b1) ends++;
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL play_seq cycle %0d: got %s, want %s", cyc, fmt(obs()), fmt(expv()));
      end
    end
    n_checks++;
    if (ends != 1 || busy !== 1'b0 || rom_addr !== 3'd0 || note_valid !== 1'b0) begin
      n_fail++; $display("FAIL song_done: ends=%0d %s, want ends=1 addr=0 vld=0 busy=0", ends, fmt(obs()));
    end
  endtask

  task automatic test_loop();
    int ends = 0;
    bit dropped = 0;
    loop_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 70; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (song_end === 1'b1) ends++;
      if (busy !== 1'b1) dropped = 1;
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL loop cycle %0d: got %s, want %s", cyc, fmt(obs()), fmt(expv()));
      end
    end
    n_checks++;
    if (ends != 2 || dropped) begin
      n_fail++; $display("FAIL loop_wrap: ends=%0d dropped=%0b, want ends=2 dropped=0", ends, dropped);
    end
    loop_en = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_pause();
    int budget = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    while (!(m_pos == 2 && m_elapsed == 2) && budget < 40) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      budget++;
    end
    n_checks++;
    if (budget >= 40) begin
      n_fail++; $display("FAIL pause_reach: timeout, addr=%0d want 2", rom_addr);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (note_valid !== 1'b0 || busy !== 1'b1 || rom_addr !== 3'd2) begin
      n_fail++; $display("FAIL pause_enter: %s, want addr=2 vld=0 busy=1", fmt(obs()));
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== expv() || rom_addr !== 3'd2) begin
        n_fail++; $display("FAIL pause_hold cycle %0d: got %s, want %s", cyc, fmt(obs()), fmt(expv()));
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rom_addr !== 3'd2) begin
      n_fail++; $display("FAIL resume_hold: addr=%0d, want 2", rom_addr);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rom_addr !== 3'd3) begin
      n_fail++; $display("FAIL resume_step: addr=%0d, want 3", rom_addr);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_tempo();
    tempo_sel = 2'd1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rom_addr !== 3'd2) begin
      n_fail++; $display("FAIL tempo_fast: addr=%0d after 4 clks, want 2", rom_addr);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tempo_sel = 2'd2;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rom_addr !== 3'd0) begin
      n_fail++; $display("FAIL tempo_slow_hold: addr=%0d after 7 clks, want 0", rom_addr);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rom_addr !== 3'd1) begin
      n_fail++; $display("FAIL tempo_slow_step: addr=%0d after 8 clks, want 1", rom_addr);
    end
    tempo_sel = 2'd0;
  endtask

  task automatic test_stop_play();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs() !== 11'd0) begin
      n_fail++; $display("FAIL stop_play_same: got %s, want idle", fmt(obs()));
    end
  endtask

  task automatic test_rst_mid();
    int budget = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    while (rom_addr !== 3'd5 && budget < 40) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      budget++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (budget >= 40 || note !== 3'd3 || octave !== 2'd2) begin
      n_fail++; $display("FAIL addr5_note: %s, want addr=5 note=3 oct=2", fmt(obs()));
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs() !== 11'd0) begin
      n_fail++; $display("FAIL rst_mid: got %s, want all zero", fmt(obs()));
    end
  endtask

  task automatic test_random();
    logic p, pa, st, r;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(49) == 0) tempo_sel = 2'($urandom_range(3));
      if ($urandom_range(59) == 0) loop_en = 1'($urandom_range(1));
      p  = ($urandom_range(7) == 0);
      pa = ($urandom_range(9) == 0);
      st = ($urandom_range(39) == 0);
      r  = ($urandom_range(299) == 0);
      step(p, pa, st, r);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random cycle %0d: got %s, want %s", cyc, fmt(obs()), fmt(expv()));
      end
    end
  endtask

  initial begin
    rst = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0;
    loop_en = 1'b0; tempo_sel = 2'd0;
    test_reset();
    test_play_sequence();
    test_loop();
    test_pause();
    test_tempo();
    test_stop_play();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
